// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: shift-add multiply and
// restoring divide, one bit per cycle, with pipeline stall and done handshake.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] data1_i,
  input  logic [XLEN-1:0] data2_i,
  input  logic            MemStall_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state_q, state_d;
  logic [4:0]        cnt_q;
  logic [2:0]        op_q;
  logic              neg1_q, neg2_q;
  logic [XLEN-1:0]   mcand_q;   // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] prod_q;    // {accumulator, remaining multiplier bits}
  logic [XLEN:0]     rem_q;
  logic [XLEN-1:0]   quo_q;     // dividend shifts out as quotient shifts in

  // operand decode in IDLE
  logic            sgn1, sgn2, neg1, neg2, is_div, div_zero, div_ovf, special;
  logic [XLEN-1:0] mag1, mag2, special_res;

  always_comb begin
    sgn1 = 1'b0;
    sgn2 = 1'b0;
    case (funct3_i)
      3'd1, 3'd4, 3'd6: begin sgn1 = 1'b1; sgn2 = 1'b1; end
      3'd2:             sgn1 = 1'b1;
      default:          ;
    endcase
    neg1     = sgn1 & data1_i[XLEN-1];
    neg2     = sgn2 & data2_i[XLEN-1];
    mag1     = neg1 ? -data1_i : data1_i;
    mag2     = neg2 ? -data2_i : data2_i;
    is_div   = funct3_i[2];
    div_zero = is_div & (data2_i == '0);
    div_ovf  = is_div & ~funct3_i[0] & (data1_i == {1'b1, {(XLEN-1){1'b0}}})
               & (data2_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_res = funct3_i[1] ? data1_i : '1;
    else          special_res = funct3_i[1] ? '0 : data1_i;
  end

  // one iteration of each datapath
  logic [XLEN:0]     mul_sum, shifted, rem_nxt;
  logic [2*XLEN-1:0] prod_nxt, prod_fix;
  logic [XLEN-1:0]   quo_nxt, quo_fix, rem_fix, rem_lo, res_calc;
  logic              take;

  always_comb begin
    mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_nxt = {mul_sum, prod_q[XLEN-1:1]};
    shifted  = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    take     = shifted >= {1'b0, mcand_q};
    rem_nxt  = take ? shifted - {1'b0, mcand_q} : shifted;
    quo_nxt  = {quo_q[XLEN-2:0], take};
    // sign fix-up applied to the final iteration so result lands on DONE entry
    prod_fix = (neg1_q ^ neg2_q) ? -prod_nxt : prod_nxt;
    quo_fix  = (neg1_q ^ neg2_q) ? -quo_nxt : quo_nxt;
    rem_lo   = rem_nxt[XLEN-1:0];
    rem_fix  = neg1_q ? -rem_lo : rem_lo;
    case (op_q)
      3'd0:             res_calc = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res_calc = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       res_calc = quo_fix;
      default:          res_calc = rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i && !MemStall_i) state_d = special ? DONE : CALC;
      CALC:    if (!MemStall_i && cnt_q == 5'd0) state_d = DONE;
      DONE:    if (!MemStall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i) state_d = IDLE;
  end

  assign stall_o = ~rst_i & (((state_q == IDLE) & start_i) | (state_q == CALC));
  assign done_o  = (state_q == DONE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_o <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start_i && !MemStall_i) begin
            op_q   <= funct3_i;
            neg1_q <= neg1;
            neg2_q <= neg2;
            cnt_q  <= 5'd31;
            if (is_div) begin
              mcand_q <= mag2;
              quo_q   <= mag1;
              rem_q   <= '0;
            end else begin
              mcand_q <= mag1;
              prod_q  <= {{XLEN{1'b0}}, mag2};
            end
            if (special) result_o <= special_res;
          end
        end
        CALC: begin
          if (!MemStall_i) begin
            if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
            if (op_q[2]) begin
              rem_q <= rem_nxt;
              quo_q <= quo_nxt;
            end else begin
              prod_q <= prod_nxt;
            end
            if (cnt_q == 5'd0) result_o <= res_calc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: reference results from 64-bit arithmetic,
// latency and stall behaviour checked by the driver, results by a monitor.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, start, memstall;
  logic [2:0]  funct3;
  logic [31:0] data1, data2;
  logic        stall, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  logic [31:0] expq[$];
  logic [31:0] last_exp = '0;
  logic        done_q = 1'b0;
  logic        rst_q  = 1'b1;
  logic [31:0] res_q  = '0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .funct3_i(funct3),
    .data1_i(data1), .data2_i(data2), .MemStall_i(memstall),
    .stall_o(stall), .done_o(done), .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'b0, a});
    longint ub = longint'({32'b0, b});
    logic [63:0] p;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = sa / sb; return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = ua / ub; return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // monitor: pops on each DONE entry, checks hold and stability otherwise
  always @(negedge clk) begin
    if (!rst) begin
      if (done && !done_q) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got result %h expected no done", result);
        end else begin
          check("result", result, expq[0]);
          last_exp <= expq[0];
          void'(expq.pop_front());
        end
      end else if (done && done_q) begin
        check("result_hold", result, last_exp);
      end else if (!done && !rst_q) begin
        check("result_stable", result, res_q);
      end
    end
    done_q <= done;
    rst_q  <= rst;
    res_q  <= result;
  end

  // called at posedge+1; returns at posedge+1 after the edge that leaves DONE
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int ms_from, input int ms_len, input int ds);
    int lat, k, kd, ndone;
    bit fin;
    lat = (is_special(f, a, b) ? 1 : 33) + ms_len;
    expq.push_back(ref_model(f, a, b));
    start = 1'b1; funct3 = f; data1 = a; data2 = b;
    k = 0; kd = -1; ndone = 0; fin = 1'b0;
    while (!fin) begin
      memstall = (k >= ms_from && k < ms_from + ms_len) || (k >= lat && k < lat + ds);
      @(negedge clk);
      if (done) begin
        if (kd < 0) begin
          kd = k;
          check("latency", 32'(kd), 32'(lat));
        end
        ndone++;
        check("stall_in_done", {31'b0, stall}, 32'd0);
        if (!memstall) fin = 1'b1;
      end else begin
        check("stall_busy", {31'b0, stall}, 32'd1);
      end
      if (!fin && k > lat + ds + 20) begin
        total++;
        bad++;
        $display("FAIL timeout: got no done after %0d cycles expected done at %0d", k, lat);
        fin = 1'b1;
      end
      @(posedge clk); #1;
      k++;
    end
    if (kd >= 0) check("done_cycles", 32'(ndone), 32'(ds + 1));
    start = 1'b0; memstall = 1'b0;
  endtask

  task automatic run_abort();
    start = 1'b1; funct3 = 3'd0; data1 = 32'h1234_5678; data2 = 32'h9ABC_DEF0;
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    check("stall_in_reset", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_result", result, 32'd0);
    repeat (40) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    int msf, msl, ds;
    rst = 1'b1; start = 1'b0; memstall = 1'b0; funct3 = '0; data1 = '0; data2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0, 0, 0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    idle(3);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    run_op(3'd5, 32'd100, 32'd7, 0, 0, 0);
    run_op(3'd7, 32'd100, 32'd7, 0, 0, 0);
    idle(2);
    run_op(3'd5, 32'd5, 32'd0, 0, 0, 0);
    run_op(3'd6, 32'd5, 32'd0, 0, 0, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    idle(2);
    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 10, 5, 0);
    run_op(3'd0, 32'h0001_2345, 32'd678, 0, 0, 3);
    run_op(3'd5, 32'd1000, 32'd3, 0, 2, 0);
    idle(2);
    run_op(3'd5, 32'hDEAD_BEEF, 32'd1234, 0, 0, 0);
    run_op(3'd0, 32'hCAFE_F00D, 32'h0BAD_1DEA, 0, 0, 0);
    run_abort();

    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'd0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      msf = 0; msl = 0;
      if ($urandom_range(0, 3) == 0) begin
        msl = $urandom_range(1, 4);
        msf = is_special(f, a, b) ? 0 : $urandom_range(0, 20);
      end
      ds = $urandom_range(0, 2);
      run_op(f, a, b, msf, msl, ds);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    idle(3);
    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Iterative multi-cycle multiply/divide unit for the EX stage, directly downstream of the ID/EX pipeline register. It consumes the operands and funct3 of an RV32M instruction held in ID/EX and computes the result one bit per cycle. It stalls the front of the pipeline with `stall_o` until the result is ready. It then presents the result for one EX cycle so the EX/MEM register can latch it in place of the ALU result.

## Interface
Parameters:
- `XLEN`, 32, operand/result width (only 32 supported)

Ports:
- `clk_i`  in  1  clock; all state updates on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `start_i`  in  1  ID/EX holds an M-extension op (funct7 = 0000001, R-type); level, held by frozen ID/EX
- `funct3_i`  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `data1_i`  in  32  rs1 operand (already forwarded)
- `data2_i`  in  32  rs2 operand (already forwarded)
- `MemStall_i`  in  1  global memory stall; freezes this unit
- `stall_o`  out  1  freeze PC, IF/ID, ID/EX; insert nothing into EX/MEM
- `done_o`  out  1  `result_o` valid this cycle
- `result_o`  out  32  rd value

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start_i`=1 and `MemStall_i`=0: latch operands and funct3. Record signs:
    - rs1 is signed for MULH, MULHSU, DIV, REM.
    - rs2 is signed for MULH, DIV, REM.
  - Convert signed operands to magnitudes.
  - Load 5-bit counter = 31.
  - Go to CALC, except for the division special cases below, which go straight to DONE.
- CALC, multiply: shift-add into a 64-bit product register, one multiplier bit per cycle.
- CALC, divide: restoring division with a 33-bit partial remainder, one quotient bit per cycle.
- Counter decrements each CALC cycle. CALC at counter 0 → DONE.
- Sign fix-up at DONE entry:
  - Product is negated if the operand signs differ.
  - Quotient sign = s1 XOR s2.
  - Remainder sign = s1.
- Result select:
  - MUL = product[31:0].
  - MULH/MULHSU/MULHU = product[63:32].
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- Division special cases (1-cycle, no CALC):
  - Divisor 0: quotient = 0xFFFFFFFF, remainder = rs1.
  - DIV/REM with rs1 = 0x80000000 and rs2 = 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.
- DONE: `done_o`=1, `result_o` holds the value.
  - `MemStall_i`=0: return to IDLE next cycle.
  - `MemStall_i`=1: stay in DONE.
- `stall_o` = (IDLE & `start_i`) | CALC. It is combinational and low in DONE, so ID/EX advances on the DONE edge.
- `MemStall_i`=1 in CALC: counter, state and datapath hold.
- Back-to-back M ops: the next op's `start_i` is seen in IDLE the cycle after DONE and restarts normally.
- `rst_i`=1 in any state, including mid-CALC:
  - Next state IDLE.
  - Partial result discarded, no `done_o` pulse.
  - `stall_o` forced 0 while `rst_i` is high.

## Timing
- Reset values: state IDLE, `done_o` 0, `result_o` 0x00000000, `stall_o` 0, counter 0.
- Normal op, `start_i` first high at cycle T with no memory stall:
  - CALC occupies T+1..T+32.
  - DONE at T+33 with `done_o`=1.
  - `stall_o` is high T..T+32 and low at T+33.
- Special-case divide: DONE at T+1; `stall_o` high only at T.
- Each `MemStall_i` cycle in IDLE-with-start, CALC or DONE adds exactly one cycle to the remaining latency.
- `done_o` stays high for every cycle spent in DONE.
- `result_o` is registered and only changes on DONE entry or reset.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3), start at T → `result_o` = 0xFFFFFFEB, `done_o` at T+33, `stall_o` high T..T+32.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD. REM −7 % 2 → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 % 7 → 2. All done at T+33.
- DIVU 5 / 0 → 0xFFFFFFFF and REM 5 % 0 → 5, both done at T+1. DIV 0x80000000 / −1 → 0x80000000 and REM → 0, done at T+1.
- MUL with `MemStall_i` high for 5 cycles mid-CALC → done at T+38, result unchanged.
- `MemStall_i` high 3 cycles in DONE → `done_o` held 4 cycles.
- `rst_i` pulsed at CALC cycle 10 → IDLE next cycle, `stall_o` 0, `done_o` never asserted.
- Back-to-back DIVU then MUL → the second op's `start_i` is accepted the cycle after the first op's DONE; both results correct.
